// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// ALU operation selects and the decoded instruction-class bundle.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  typedef struct packed {
    logic r;
    logic lw;
    logic sw;
    logic beq;
    logic ori;
    logic lui;
    logic j;
    logic ill;
  } iclass_t;

endpackage

// File: rtl/mips_main_decode.sv
// Combinational main decoder: latched opcode -> one-hot instruction class,
// with anything outside the supported set reported as illegal.
module mips_main_decode
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] i_op,
  output iclass_t         o_cls
);

  // One-hot class lookup; unknown opcodes fall into the illegal class
  always_comb begin
    o_cls = '0;
    case (i_op)
      OP_W'(OP_R):   o_cls.r   = 1'b1;
      OP_W'(OP_LW):  o_cls.lw  = 1'b1;
      OP_W'(OP_SW):  o_cls.sw  = 1'b1;
      OP_W'(OP_BEQ): o_cls.beq = 1'b1;
      OP_W'(OP_ORI): o_cls.ori = 1'b1;
      OP_W'(OP_LUI): o_cls.lui = 1'b1;
      OP_W'(OP_J):   o_cls.j   = 1'b1;
      default:       o_cls.ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, Moore
// datapath strobes with combinational ready/zero gating, retired counter.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W          = 6,
  parameter int CNT_W         = 32,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [OP_W-1:0]  i_op_in,
  input  logic             i_mem_ready,
  input  logic             i_zero,
  output logic             o_mem_req,
  output logic             o_pc_write,
  output logic             o_ir_write,
  output logic             o_reg_dst,
  output logic             o_alu_src,
  output logic             o_mem_to_reg,
  output logic             o_reg_write,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_branch,
  output logic             o_jump,
  output logic             o_lui,
  output logic [1:0]       o_alu_op,
  output logic [2:0]       o_state,
  output logic             o_instr_done,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired_cnt
);

  state_t           r_state, w_state_nxt;
  logic [OP_W-1:0]  r_op;
  logic [CNT_W-1:0] r_retired_cnt;
  iclass_t          w_cls;
  logic             w_ready, w_op_load;
  logic             w_mem_req, w_pc_write, w_ir_write, w_reg_dst, w_alu_src;
  logic             w_mem_to_reg, w_reg_write, w_mem_read, w_mem_write;
  logic             w_branch, w_jump, w_lui, w_instr_done, w_illegal;
  logic [1:0]       w_alu_op;

  assign w_ready = MEM_HANDSHAKE ? i_mem_ready : 1'b1;

  mips_main_decode #(.OP_W(OP_W)) u_decode (
    .i_op  (r_op),
    .o_cls (w_cls)
  );

  // State, latched opcode and retired-instruction counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_FETCH;
      r_op          <= '0;
      r_retired_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_op_load) begin
        r_op <= i_op_in;
      end
      if (w_instr_done) begin
        r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state and per-state strobe generation
  always_comb begin
    w_state_nxt  = r_state;
    w_op_load    = 1'b0;
    w_mem_req    = 1'b0;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_lui        = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    w_alu_op     = ALU_ADD;
    case (r_state)
      ST_FETCH: begin
        w_mem_req  = 1'b1;
        w_mem_read = 1'b1;
        if (w_ready) begin
          w_ir_write  = 1'b1;
          w_pc_write  = 1'b1;
          w_op_load   = 1'b1;
          w_state_nxt = ST_DECODE;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (w_cls.j) begin
          w_jump       = 1'b1;
          w_pc_write   = 1'b1;
          w_instr_done = 1'b1;
          w_state_nxt  = ST_FETCH;
        end else if (w_cls.ill) begin
          w_illegal   = 1'b1;
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_alu_src = w_cls.lw | w_cls.sw | w_cls.ori | w_cls.lui;
        if (w_cls.r) begin
          w_alu_op = ALU_FUNCT;
        end else if (w_cls.beq) begin
          w_alu_op = ALU_SUB;
        end else if (w_cls.ori) begin
          w_alu_op = ALU_OR;
        end else begin
          w_alu_op = ALU_ADD;
        end
        if (w_cls.beq) begin
          w_branch     = i_zero;
          w_pc_write   = i_zero;
          w_instr_done = 1'b1;
          w_state_nxt  = ST_FETCH;
        end else if (w_cls.lw | w_cls.sw) begin
          w_state_nxt = ST_MEM;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        w_mem_req   = 1'b1;
        w_mem_read  = w_cls.lw;
        w_mem_write = w_cls.sw;
        if (!w_ready) begin
          w_state_nxt = ST_MEM;
        end else if (w_cls.sw) begin
          w_instr_done = 1'b1;
          w_state_nxt  = ST_FETCH;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      ST_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = w_cls.r;
        w_mem_to_reg = w_cls.lw;
        w_lui        = w_cls.lui;
        w_instr_done = 1'b1;
        w_state_nxt  = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Reset forces every strobe low without waiting for a clock edge
  assign o_mem_req     = i_rst_n & w_mem_req;
  assign o_pc_write    = i_rst_n & w_pc_write;
  assign o_ir_write    = i_rst_n & w_ir_write;
  assign o_reg_dst     = i_rst_n & w_reg_dst;
  assign o_alu_src     = i_rst_n & w_alu_src;
  assign o_mem_to_reg  = i_rst_n & w_mem_to_reg;
  assign o_reg_write   = i_rst_n & w_reg_write;
  assign o_mem_read    = i_rst_n & w_mem_read;
  assign o_mem_write   = i_rst_n & w_mem_write;
  assign o_branch      = i_rst_n & w_branch;
  assign o_jump        = i_rst_n & w_jump;
  assign o_lui         = i_rst_n & w_lui;
  assign o_instr_done  = i_rst_n & w_instr_done;
  assign o_illegal     = i_rst_n & w_illegal;
  assign o_alu_op      = {2{i_rst_n}} & w_alu_op;
  assign o_state       = r_state;
  assign o_retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle state/strobe/alu_op
// vectors for each instruction class, reset abort and 4-bit counter wrap.
module tb_mips_multicycle_ctrl;

  localparam logic [13:0] B_MREQ = 14'h2000, B_MRD = 14'h1000, B_MWR  = 14'h0800;
  localparam logic [13:0] B_IRW  = 14'h0400, B_PCW = 14'h0200, B_RDST = 14'h0100;
  localparam logic [13:0] B_ASRC = 14'h0080, B_M2R = 14'h0040, B_RW   = 14'h0020;
  localparam logic [13:0] B_BR   = 14'h0010, B_J   = 14'h0008, B_LUI  = 14'h0004;
  localparam logic [13:0] B_DONE = 14'h0002, B_ILL = 14'h0001, B_NONE = 14'h0000;
  localparam logic [13:0] F_OK   = B_MREQ | B_MRD | B_IRW | B_PCW;
  localparam logic [13:0] F_WAIT = B_MREQ | B_MRD;

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_ORI = 6'b001101, T_LUI = 6'b001111;
  localparam logic [5:0] T_J = 6'b000010, T_BAD = 6'b111111;

  logic clk = 1'b0;
  logic rst_n, mem_ready, zero;
  logic [5:0] op_in;

  logic mem_req, pc_write, ir_write, reg_dst, alu_src, mem_to_reg, reg_write;
  logic mem_read, mem_write, branch, jump, lui, instr_done, illegal;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic [31:0] retired_cnt;

  logic d4_mem_req, d4_pc_write, d4_ir_write, d4_reg_dst, d4_alu_src, d4_mem_to_reg;
  logic d4_reg_write, d4_mem_read, d4_mem_write, d4_branch, d4_jump, d4_lui;
  logic d4_instr_done, d4_illegal;
  logic [1:0] d4_alu_op;
  logic [2:0] d4_state;
  logic [3:0] d4_retired_cnt;

  logic [13:0] act_strb;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign act_strb = {mem_req, mem_read, mem_write, ir_write, pc_write, reg_dst, alu_src,
                     mem_to_reg, reg_write, branch, jump, lui, instr_done, illegal};

  mips_multicycle_ctrl u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_op_in(op_in), .i_mem_ready(mem_ready), .i_zero(zero),
    .o_mem_req(mem_req), .o_pc_write(pc_write), .o_ir_write(ir_write), .o_reg_dst(reg_dst),
    .o_alu_src(alu_src), .o_mem_to_reg(mem_to_reg), .o_reg_write(reg_write),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_branch(branch), .o_jump(jump),
    .o_lui(lui), .o_alu_op(alu_op), .o_state(state), .o_instr_done(instr_done),
    .o_illegal(illegal), .o_retired_cnt(retired_cnt)
  );

  mips_multicycle_ctrl #(.CNT_W(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_op_in(op_in), .i_mem_ready(mem_ready), .i_zero(zero),
    .o_mem_req(d4_mem_req), .o_pc_write(d4_pc_write), .o_ir_write(d4_ir_write),
    .o_reg_dst(d4_reg_dst), .o_alu_src(d4_alu_src), .o_mem_to_reg(d4_mem_to_reg),
    .o_reg_write(d4_reg_write), .o_mem_read(d4_mem_read), .o_mem_write(d4_mem_write),
    .o_branch(d4_branch), .o_jump(d4_jump), .o_lui(d4_lui), .o_alu_op(d4_alu_op),
    .o_state(d4_state), .o_instr_done(d4_instr_done), .o_illegal(d4_illegal),
    .o_retired_cnt(d4_retired_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Called just after a rising edge: drive inputs, check at the falling edge
  task automatic cyc(input string tag, input logic [5:0] op, input logic rdy, input logic z,
                     input logic [2:0] exp_st, input logic [13:0] exp_sb,
                     input logic [1:0] exp_ao);
    op_in = op;
    mem_ready = rdy;
    zero = z;
    @(negedge clk);
    check_eq({tag, "_state"}, 32'(state), 32'(exp_st));
    check_eq({tag, "_strobes"}, 32'(act_strb), 32'(exp_sb));
    check_eq({tag, "_alu_op"}, 32'(alu_op), 32'(exp_ao));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    op_in = 6'd0;
    mem_ready = 1'b0;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_strobes", 32'(act_strb), 32'd0);
    check_eq("rst_cnt", retired_cnt, 32'd0);
    rst_n = 1'b1;

    // lw, memory always ready: 5 cycles
    cyc("lw_f", T_LW, 1'b1, 1'b0, 3'd0, F_OK, 2'b00);
    cyc("lw_d", T_LW, 1'b1, 1'b0, 3'd1, B_NONE, 2'b00);
    cyc("lw_e", T_LW, 1'b1, 1'b0, 3'd2, B_ASRC, 2'b00);
    cyc("lw_m", T_LW, 1'b1, 1'b0, 3'd3, B_MREQ | B_MRD, 2'b00);
    cyc("lw_w", T_LW, 1'b1, 1'b0, 3'd4, B_RW | B_M2R | B_DONE, 2'b00);
    check_eq("lw_cnt", retired_cnt, 32'd1);
    check_eq("lw_cnt4", 32'(d4_retired_cnt), 32'd1);

    // R-type with fetch stalled 3 cycles; garbage opcode must not be latched
    for (int i = 0; i < 3; i++) cyc("r_fwait", T_BAD, 1'b0, 1'b0, 3'd0, F_WAIT, 2'b00);
    cyc("r_f", T_R, 1'b1, 1'b0, 3'd0, F_OK, 2'b00);
    cyc("r_d", T_BAD, 1'b0, 1'b0, 3'd1, B_NONE, 2'b00);
    cyc("r_e", T_BAD, 1'b1, 1'b0, 3'd2, B_NONE, 2'b10);
    cyc("r_w", T_BAD, 1'b0, 1'b0, 3'd4, B_RW | B_RDST | B_DONE, 2'b00);
    check_eq("r_cnt", retired_cnt, 32'd2);

    // beq taken then not taken, 3 cycles each
    cyc("beq1_f", T_BEQ, 1'b1, 1'b1, 3'd0, F_OK, 2'b00);
    cyc("beq1_d", T_BEQ, 1'b0, 1'b1, 3'd1, B_NONE, 2'b00);
    cyc("beq1_e", T_BEQ, 1'b0, 1'b1, 3'd2, B_BR | B_PCW | B_DONE, 2'b01);
    cyc("beq0_f", T_BEQ, 1'b1, 1'b0, 3'd0, F_OK, 2'b00);
    cyc("beq0_d", T_BEQ, 1'b1, 1'b0, 3'd1, B_NONE, 2'b00);
    cyc("beq0_e", T_BEQ, 1'b1, 1'b0, 3'd2, B_DONE, 2'b01);
    check_eq("beq_cnt", retired_cnt, 32'd4);

    // Illegal opcode: pulse in DECODE, back to FETCH, no retire
    cyc("ill_f", T_BAD, 1'b1, 1'b0, 3'd0, F_OK, 2'b00);
    cyc("ill_d", T_BAD, 1'b1, 1'b0, 3'd1, B_ILL, 2'b00);
    check_eq("ill_cnt", retired_cnt, 32'd4);

    // j: 2 cycles, jump and pc_write in DECODE
    cyc("j_f", T_J, 1'b1, 1'b0, 3'd0, F_OK, 2'b00);
    cyc("j_d", T_J, 1'b1, 1'b0, 3'd1, B_J | B_PCW | B_DONE, 2'b00);
    check_eq("j_cnt", retired_cnt, 32'd5);

    // ori and lui through WB
    cyc("ori_f", T_ORI, 1'b1, 1'b0, 3'd0, F_OK, 2'b00);
    cyc("ori_d", T_ORI, 1'b1, 1'b0, 3'd1, B_NONE, 2'b00);
    cyc("ori_e", T_ORI, 1'b1, 1'b0, 3'd2, B_ASRC, 2'b11);
    cyc("ori_w", T_ORI, 1'b1, 1'b0, 3'd4, B_RW | B_DONE, 2'b00);
    cyc("lui_f", T_LUI, 1'b1, 1'b0, 3'd0, F_OK, 2'b00);
    cyc("lui_d", T_LUI, 1'b1, 1'b0, 3'd1, B_NONE, 2'b00);
    cyc("lui_e", T_LUI, 1'b1, 1'b0, 3'd2, B_ASRC, 2'b00);
    cyc("lui_w", T_LUI, 1'b1, 1'b0, 3'd4, B_RW | B_LUI | B_DONE, 2'b00);
    check_eq("ori_lui_cnt", retired_cnt, 32'd7);

    // sw with one MEM wait cycle
    cyc("sw_f", T_SW, 1'b1, 1'b0, 3'd0, F_OK, 2'b00);
    cyc("sw_d", T_SW, 1'b1, 1'b0, 3'd1, B_NONE, 2'b00);
    cyc("sw_e", T_SW, 1'b1, 1'b0, 3'd2, B_ASRC, 2'b00);
    cyc("sw_mwait", T_SW, 1'b0, 1'b0, 3'd3, B_MREQ | B_MWR, 2'b00);
    cyc("sw_m", T_SW, 1'b1, 1'b0, 3'd3, B_MREQ | B_MWR | B_DONE, 2'b00);
    check_eq("sw_cnt", retired_cnt, 32'd8);

    // sw aborted by reset while stalled in MEM
    cyc("swa_f", T_SW, 1'b1, 1'b0, 3'd0, F_OK, 2'b00);
    cyc("swa_d", T_SW, 1'b1, 1'b0, 3'd1, B_NONE, 2'b00);
    cyc("swa_e", T_SW, 1'b0, 1'b0, 3'd2, B_ASRC, 2'b00);
    cyc("swa_m", T_SW, 1'b0, 1'b0, 3'd3, B_MREQ | B_MWR, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_mem_write", 32'(mem_write), 32'd0);
    check_eq("abort_state", 32'(state), 32'd0);
    check_eq("abort_strobes", 32'(act_strb), 32'd0);
    check_eq("abort_cnt", retired_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 17 back-to-back j: 4-bit counter wraps to 1
    for (int k = 0; k < 17; k++) begin
      cyc("wrap_f", T_J, 1'b1, 1'b0, 3'd0, F_OK, 2'b00);
      cyc("wrap_d", T_J, 1'b1, 1'b0, 3'd1, B_J | B_PCW | B_DONE, 2'b00);
    end
    check_eq("wrap_cnt4", 32'(d4_retired_cnt), 32'd1);
    check_eq("wrap_cnt32", retired_cnt, 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
